imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream programmer for the pipeline's writable instruction memory. Receives a length-prefixed program image over a valid/ready byte interface and assembles little-endian 32-bit words. Writes each word into the instruction memory write port at consecutive word addresses starting at 0. Holds the CPU while a load is in progress, and signals completion or error.

## Interface
- `DEPTH`, 256: instruction memory depth in words; the memory is indexed by `Address[9:2]`.
- `TIMEOUT`, 1000000: idle cycles allowed between accepted bytes once a frame has started. Minimum value is 2.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  the loader can accept a byte. A byte transfers on a cycle with `rx_valid && rx_ready`.
- `imem_we`  out  1  instruction memory write enable; a one-cycle pulse per word.
- `imem_addr`  out  32  byte address of the write; always word-aligned.
- `imem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  high while a load is in progress; the pipeline is held in reset while it is high.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  one-cycle pulse when a frame is aborted.
- `words_loaded`  out  9  number of words written by the most recent successful load.

## Operation
- Frame format:
  - 2 bytes: word count N, little-endian.
  - Then N×4 bytes: each word sent byte0 first, so data = {b3,b2,b1,b0}.
- States: LEN0, LEN1, DATA, DONE, ERR. Reset enters LEN0.
- `rx_ready` = 1 in LEN0, LEN1 and DATA; 0 in DONE and ERR; 0 while `reset` is low.
- LEN0: an accepted byte latches N[7:0] → LEN1. `cpu_hold` rises on the next cycle.
- LEN1: an accepted byte latches N[15:8].
  - If 1 ≤ N ≤ DEPTH → DATA, with word index w=0 and byte index b=0.
  - Otherwise → ERR.
- DATA:
  - Each accepted byte is shifted in and b increments.
  - On the 4th byte (b=3), the next cycle has `imem_we`=1, `imem_addr`={w,2'b00} and `imem_wdata` = the assembled word. Then w increments and b clears.
  - When w reaches N-1 and its 4th byte is accepted, the state → DONE.
  - Bytes of the following word may be accepted on the same cycle as a write.
- DONE (1 cycle): `done`=1, `words_loaded`=N, `cpu_hold` falls on the next cycle → LEN0.
- ERR (1 cycle): `err`=1, `cpu_hold` falls on the next cycle → LEN0.
  - `words_loaded` is unchanged.
  - Words already written stay in memory.
  - A partial word is discarded and never written.
- Timeout: an idle counter clears on every accepted byte and on entry to LEN1 or DATA. It counts only in LEN1 and DATA. When it reaches TIMEOUT-1 → ERR. LEN0 never times out.
- `imem_addr` increments by 4 per write. The last address for N=DEPTH=256 is 0x3FC; it never wraps within a frame.

## Timing
- Reset values (all registered): `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `done`=0, `err`=0, `cpu_hold`=0, `words_loaded`=0, state=LEN0.
- Write latency: `imem_we` is asserted exactly 1 cycle after the transfer of the word's 4th byte.
- For the last word, the `imem_we` pulse and the `done` pulse are on the same cycle.
- `cpu_hold` is high from 1 cycle after the first length byte through the `done`/`err` cycle inclusive.
- At most one `imem_we` per cycle. `imem_addr` and `imem_wdata` hold their last values when `imem_we`=0.
- Reset mid-frame: no further writes occur, all outputs return to their reset values on the next edge, no `done`/`err` pulse is produced, and the next byte is treated as LEN0.
- `rx_valid` with no transfer (`rx_ready`=0) loses no data; the source must hold the byte until it transfers.
- Throughput: 1 byte per cycle with continuous `rx_valid`.

## Test plan
- Frame 03 00 | 21 00 10 00 | 04 00 05 21 | 0b 00 10 0c with `rx_valid` held high:
  - 3 `imem_we` pulses at addresses 0x0, 0x4, 0x8 with data 0x00100021, 0x21050004, 0x0c10000b.
  - `done` on the 3rd write cycle; `words_loaded`=3.
  - `cpu_hold` high from the cycle after the first byte through `done`.
- N=0 (00 00), then N=257 (01 01): each gives `err` one cycle after the 2nd length byte, with no writes; `rx_ready` is 0 only on the ERR cycle.
- TIMEOUT=8: send 01 00 aa bb, then idle → `err` 8 cycles after the last accepted byte, no write, and the next byte is accepted as LEN0.
- Random `rx_valid` gaps (below timeout) on a 2-word frame → same writes and data as the gap-free run.
- N=256 of incrementing words → last write at 0x3FC with data 0x000000FF; `words_loaded`=256.
- Assert `reset` after 6 data bytes of a 2-word frame → exactly 1 write (the first word) occurred; all outputs are at reset values after the edge; a fresh 1-word frame then loads at address 0.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Loads a program image into the writable instruction memory from a byte
// stream. A frame is a 2-byte little-endian word count N followed by N words,
// each sent least-significant byte first. Words are written to consecutive
// word addresses starting at 0. The CPU is held while a frame is in progress.
// A frame ends with a one-cycle done pulse, or with a one-cycle err pulse on a
// bad length or an idle timeout.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   rx_data       incoming byte
//   rx_valid      rx_data is valid
//   rx_ready      loader can take a byte (transfer = rx_valid && rx_ready)
//   imem_we       one-cycle write strobe per assembled word
//   imem_addr     word-aligned byte address of the write
//   imem_wdata    assembled word
//   cpu_hold      high while a frame is being loaded
//   done          one-cycle pulse when a frame completes
//   err           one-cycle pulse when a frame is aborted
//   words_loaded  word count of the most recent successful load
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int DEPTH   = 256,
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        err,
   output logic [8:0]  words_loaded
);

   localparam int IW = $clog2(TIMEOUT);
   // The abort fires on the edge where the idle count would reach TIMEOUT-1,
   // so err appears TIMEOUT cycles after the last accepted byte.
   localparam logic [IW-1:0] idle_last = IW'(TIMEOUT - 2);
   localparam logic [16:0]   depth_max = 17'(DEPTH);

   typedef enum logic [2:0] {
      s_len0,
      s_len1,
      s_data,
      s_done,
      s_err
   } state_t;

   state_t         state_reg, state_next;
   logic [7:0]     len_lo_reg, len_lo_next;
   logic [15:0]    n_reg, n_next;
   logic [8:0]     w_reg, w_next;
   logic [1:0]     b_reg, b_next;
   logic [31:0]    word_reg, word_next;
   logic [IW-1:0]  idle_reg, idle_next;
   logic           we_reg, we_next;
   logic [31:0]    addr_reg, addr_next;
   logic [31:0]    wdata_reg, wdata_next;
   logic           hold_reg, hold_next;
   logic           done_reg, done_next;
   logic           err_reg, err_next;
   logic [8:0]     loaded_reg, loaded_next;

   logic           xfer;
   logic [31:0]    shifted;
   logic [15:0]    len_in;

   assign rx_ready = reset && (state_reg == s_len0 || state_reg == s_len1 ||
                               state_reg == s_data);
   assign xfer     = rx_valid && rx_ready;
   assign len_in   = {rx_data, len_lo_reg};

   // Bytes enter at the top and move down one lane per accepted byte, so
   // after four bytes the word reads {b3,b2,b1,b0}.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         assign shifted[8*gi +: 8] = word_reg[8*gi+8 +: 8];
      end
   endgenerate
   assign shifted[31:24] = rx_data;

   always_comb begin
      state_next  = state_reg;
      len_lo_next = len_lo_reg;
      n_next      = n_reg;
      w_next      = w_reg;
      b_next      = b_reg;
      word_next   = word_reg;
      idle_next   = idle_reg;
      we_next     = 1'b0;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      hold_next   = hold_reg;
      done_next   = 1'b0;
      err_next    = 1'b0;
      loaded_next = loaded_reg;

      unique case (state_reg)
         s_len0: begin
            if (xfer) begin
               len_lo_next = rx_data;
               hold_next   = 1'b1;
               idle_next   = '0;
               state_next  = s_len1;
            end
         end
         s_len1: begin
            if (xfer) begin
               n_next = len_in;
               if (len_in != 16'd0 && {1'b0, len_in} <= depth_max) begin
                  w_next     = '0;
                  b_next     = '0;
                  idle_next  = '0;
                  state_next = s_data;
               end else begin
                  err_next   = 1'b1;
                  state_next = s_err;
               end
            end else if (idle_reg == idle_last) begin
               err_next   = 1'b1;
               state_next = s_err;
            end else begin
               idle_next = idle_reg + IW'(1);
            end
         end
         s_data: begin
            if (xfer) begin
               word_next = shifted;
               idle_next = '0;
               b_next    = b_reg + 2'd1;
               if (b_reg == 2'd3) begin
                  we_next    = 1'b1;
                  addr_next  = {21'd0, w_reg, 2'b00};
                  wdata_next = shifted;
                  w_next     = w_reg + 9'd1;
                  if ({7'd0, w_reg} == n_reg - 16'd1) begin
                     done_next   = 1'b1;
                     loaded_next = n_reg[8:0];
                     state_next  = s_done;
                  end
               end
            end else if (idle_reg == idle_last) begin
               // Any partially assembled word is simply dropped.
               err_next   = 1'b1;
               state_next = s_err;
            end else begin
               idle_next = idle_reg + IW'(1);
            end
         end
         s_done, s_err: begin
            hold_next  = 1'b0;
            state_next = s_len0;
         end
         default: begin
            state_next = s_len0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= s_len0;
         len_lo_reg <= '0;
         n_reg      <= '0;
         w_reg      <= '0;
         b_reg      <= '0;
         word_reg   <= '0;
         idle_reg   <= '0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         hold_reg   <= 1'b0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
         loaded_reg <= '0;
      end else begin
         state_reg  <= state_next;
         len_lo_reg <= len_lo_next;
         n_reg      <= n_next;
         w_reg      <= w_next;
         b_reg      <= b_next;
         word_reg   <= word_next;
         idle_reg   <= idle_next;
         we_reg     <= we_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         hold_reg   <= hold_next;
         done_reg   <= done_next;
         err_reg    <= err_next;
         loaded_reg <= loaded_next;
      end
   end

   assign imem_we      = we_reg;
   assign imem_addr    = addr_reg;
   assign imem_wdata   = wdata_reg;
   assign cpu_hold     = hold_reg;
   assign done         = done_reg;
   assign err          = err_reg;
   assign words_loaded = loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Frames are built from lists of words;
// the expected memory writes are simply "word i at byte address 4*i". A
// negedge monitor logs writes, done/err pulses and cpu_hold edges with cycle
// stamps; each test task compares those logs against its expectations.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int DEPTH   = 256;
   localparam int TIMEOUT = 8;

   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];
   typedef struct packed {
      int          c;
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [8:0]  words_loaded;

   imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold),
      .done(done),
      .err(err),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // monitor state
   wr_t  wr_q[$];
   int   done_cnt = 0, err_cnt = 0;
   int   done_cyc = -1, err_cyc = -1;
   int   hold_rise_cyc = -1, hold_fall_cyc = -1;
   logic prev_hold = 1'b0;
   int   last_xfer_cyc = -1, first_xfer_cyc = -1, last_wait = 0;

   always @(negedge clk) begin
      if (imem_we === 1'b1) wr_q.push_back('{cyc, imem_addr, imem_wdata});
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (cpu_hold === 1'b1 && !prev_hold) hold_rise_cyc = cyc;
      if (cpu_hold !== 1'b1 && prev_hold) hold_fall_cyc = cyc;
      prev_hold = (cpu_hold === 1'b1);
   end

   task automatic clear_mon();
      @(negedge clk);
      #1;
      wr_q.delete();
      done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
      hold_rise_cyc = -1; hold_fall_cyc = -1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      last_wait = t;
      checks++;
      if (rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_byte: rx_ready=%b, required 1 within 40 cycles", rx_ready);
      end else begin
         last_xfer_cyc = cyc;
         @(posedge clk);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input bq_t q, input int maxgap);
      for (int i = 0; i < q.size(); i++) begin
         if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
         send_byte(q[i]);
         if (i == 0) first_xfer_cyc = last_xfer_cyc;
      end
   endtask

   task automatic build_frame(input int n, input wq_t words, output bq_t q);
      logic [15:0] nn;
      logic [31:0] tmp;
      q = {};
      nn = 16'(n);
      q.push_back(nn[7:0]);
      q.push_back(nn[15:8]);
      foreach (words[i]) begin
         for (int k = 0; k < 4; k++) begin
            tmp = words[i] >> (8 * k);
            q.push_back(tmp[7:0]);
         end
      end
   endtask

   task automatic wait_end(input int budget);
      int t;
      t = 0;
      #1;
      while (done_cnt + err_cnt == 0 && t < budget) begin
         @(negedge clk);
         #1;
         t++;
      end
      checks++;
      if (done_cnt + err_cnt == 0) begin
         errors++;
         $display("FAIL wait_end: no done/err within %0d cycles", budget);
      end
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx_valid = 1'b1;
      rx_data = 8'h55;
      repeat (3) @(negedge clk);
      checks++;
      if ({imem_we, imem_addr, imem_wdata, cpu_hold, done, err, words_loaded, rx_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h hold=%b done=%b err=%b wl=%0d rdy=%b, required all 0",
                  imem_we, imem_addr, imem_wdata, cpu_hold, done, err, words_loaded, rx_ready);
      end
      rx_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b1 || cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b hold=%b, required rdy=1 hold=0", rx_ready, cpu_hold);
      end
   endtask

   task automatic test_basic();
      wq_t w;
      bq_t q;
      w = '{32'h00100021, 32'h21050004, 32'h0c10000b};
      build_frame(3, w, q);
      clear_mon();
      send_frame(q, 0);
      wait_end(20);
      checks++;
      if (wr_q.size() != 3) begin
         errors++;
         $display("FAIL basic_count: got %0d writes, required 3", wr_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_q[i].a !== 32'(4 * i) || wr_q[i].d !== w[i]) begin
               errors++;
               $display("FAIL basic_write%0d: got addr=%h data=%h, required addr=%h data=%h",
                        i, wr_q[i].a, wr_q[i].d, 32'(4 * i), w[i]);
            end
         end
         checks++;
         if (wr_q[2].c != last_xfer_cyc + 1 || done_cyc != wr_q[2].c) begin
            errors++;
            $display("FAIL basic_done_timing: last write cyc %0d done cyc %0d, required both %0d",
                     wr_q[2].c, done_cyc, last_xfer_cyc + 1);
         end
      end
      checks++;
      if (done_cnt != 1 || err_cnt != 0 || words_loaded !== 9'd3) begin
         errors++;
         $display("FAIL basic_status: done=%0d err=%0d words_loaded=%0d, required 1 0 3",
                  done_cnt, err_cnt, words_loaded);
      end
      checks++;
      if (hold_rise_cyc != first_xfer_cyc + 1 || hold_fall_cyc != done_cyc + 1) begin
         errors++;
         $display("FAIL basic_hold: rise %0d fall %0d, required %0d %0d",
                  hold_rise_cyc, hold_fall_cyc, first_xfer_cyc + 1, done_cyc + 1);
      end
      checks++;
      if (last_xfer_cyc - first_xfer_cyc != 13) begin
         errors++;
         $display("FAIL basic_throughput: %0d cycles for 14 bytes, required 13", last_xfer_cyc - first_xfer_cyc);
      end
   endtask

   task automatic test_bad_len();
      int lens[2];
      logic [15:0] nn;
      lens = '{0, 257};
      for (int i = 0; i < 2; i++) begin
         nn = 16'(lens[i]);
         clear_mon();
         send_byte(nn[7:0]);
         send_byte(nn[15:8]);
         checks++;
         if (err !== 1'b1 || rx_ready !== 1'b0 || last_wait != 0) begin
            errors++;
            $display("FAIL badlen_err_cycle n=%0d: err=%b rdy=%b wait=%0d, required err=1 rdy=0 wait=0",
                     lens[i], err, rx_ready, last_wait);
         end
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || rx_ready !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL badlen_after n=%0d: err=%b rdy=%b hold=%b, required 0 1 0",
                     lens[i], err, rx_ready, cpu_hold);
         end
         #1;
         checks++;
         if (err_cyc != last_xfer_cyc + 1 || wr_q.size() != 0 || done_cnt != 0 || words_loaded !== 9'd3) begin
            errors++;
            $display("FAIL badlen_status n=%0d: err cyc %0d writes %0d done %0d wl %0d, required %0d 0 0 3",
                     lens[i], err_cyc, wr_q.size(), done_cnt, words_loaded, last_xfer_cyc + 1);
         end
      end
   endtask

   task automatic test_timeout();
      wq_t w;
      bq_t q;
      clear_mon();
      q = '{8'h01, 8'h00, 8'haa, 8'hbb};
      send_frame(q, 0);
      wait_end(30);
      checks++;
      if (err_cnt != 1 || err_cyc != last_xfer_cyc + TIMEOUT || wr_q.size() != 0 || done_cnt != 0) begin
         errors++;
         $display("FAIL timeout_err: err=%0d at cyc %0d writes %0d done %0d, required 1 at %0d 0 0",
                  err_cnt, err_cyc, wr_q.size(), done_cnt, last_xfer_cyc + TIMEOUT);
      end
      checks++;
      if (cpu_hold !== 1'b0 || words_loaded !== 9'd3) begin
         errors++;
         $display("FAIL timeout_after: hold=%b wl=%0d, required 0 3", cpu_hold, words_loaded);
      end
      w = '{$urandom()};
      build_frame(1, w, q);
      clear_mon();
      send_frame(q, 0);
      wait_end(20);
      checks++;
      if (wr_q.size() != 1 || done_cnt != 1 || words_loaded !== 9'd1) begin
         errors++;
         $display("FAIL timeout_reload: writes %0d done %0d wl %0d, required 1 1 1",
                  wr_q.size(), done_cnt, words_loaded);
      end else begin
         checks++;
         if (wr_q[0].a !== 32'h0 || wr_q[0].d !== w[0]) begin
            errors++;
            $display("FAIL timeout_reload_data: got %h@%h, required %h@0", wr_q[0].d, wr_q[0].a, w[0]);
         end
      end
   endtask

   task automatic test_gaps();
      wq_t w;
      bq_t q;
      for (int it = 0; it < 4; it++) begin
         w = '{$urandom(), $urandom()};
         build_frame(2, w, q);
         clear_mon();
         send_frame(q, 3);
         wait_end(40);
         checks++;
         if (wr_q.size() != 2 || done_cnt != 1 || err_cnt != 0 || words_loaded !== 9'd2) begin
            errors++;
            $display("FAIL gaps_status it=%0d: writes %0d done %0d err %0d wl %0d, required 2 1 0 2",
                     it, wr_q.size(), done_cnt, err_cnt, words_loaded);
         end else begin
            for (int i = 0; i < 2; i++) begin
               checks++;
               if (wr_q[i].a !== 32'(4 * i) || wr_q[i].d !== w[i]) begin
                  errors++;
                  $display("FAIL gaps_write it=%0d i=%0d: got %h@%h, required %h@%h",
                           it, i, wr_q[i].d, wr_q[i].a, w[i], 32'(4 * i));
               end
            end
         end
      end
   endtask

   task automatic test_full();
      wq_t w;
      bq_t q;
      int bad;
      w = {};
      for (int i = 0; i < DEPTH; i++) w.push_back(32'(i));
      build_frame(DEPTH, w, q);
      clear_mon();
      send_frame(q, 0);
      wait_end(50);
      checks++;
      if (wr_q.size() != DEPTH || done_cnt != 1 || err_cnt != 0 || words_loaded !== 9'd256) begin
         errors++;
         $display("FAIL full_status: writes %0d done %0d err %0d wl %0d, required 256 1 0 256",
                  wr_q.size(), done_cnt, err_cnt, words_loaded);
      end else begin
         bad = 0;
         for (int i = 0; i < DEPTH; i++)
            if (wr_q[i].a !== 32'(4 * i) || wr_q[i].d !== w[i]) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL full_image: %0d words wrong, required 0", bad);
         end
         checks++;
         if (wr_q[DEPTH-1].a !== 32'h3fc || wr_q[DEPTH-1].d !== 32'hff || done_cyc != wr_q[DEPTH-1].c) begin
            errors++;
            $display("FAIL full_last: got %h@%h cyc %0d done %0d, required 000000ff@000003fc same cycle",
                     wr_q[DEPTH-1].d, wr_q[DEPTH-1].a, wr_q[DEPTH-1].c, done_cyc);
         end
      end
   endtask

   task automatic test_midreset();
      wq_t w;
      bq_t q;
      w = '{$urandom(), $urandom()};
      build_frame(2, w, q);
      clear_mon();
      for (int i = 0; i < 8; i++) send_byte(q[i]);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({imem_we, imem_addr, imem_wdata, cpu_hold, done, err, words_loaded, rx_ready} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: we=%b addr=%h wdata=%h hold=%b done=%b err=%b wl=%0d rdy=%b, required all 0",
                  imem_we, imem_addr, imem_wdata, cpu_hold, done, err, words_loaded, rx_ready);
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (wr_q.size() != 1 || done_cnt != 0 || err_cnt != 0) begin
         errors++;
         $display("FAIL midreset_writes: writes %0d done %0d err %0d, required 1 0 0",
                  wr_q.size(), done_cnt, err_cnt);
      end else begin
         checks++;
         if (wr_q[0].a !== 32'h0 || wr_q[0].d !== w[0]) begin
            errors++;
            $display("FAIL midreset_word0: got %h@%h, required %h@0", wr_q[0].d, wr_q[0].a, w[0]);
         end
      end
      w = '{$urandom()};
      build_frame(1, w, q);
      clear_mon();
      send_frame(q, 0);
      wait_end(20);
      checks++;
      if (wr_q.size() != 1 || done_cnt != 1 || words_loaded !== 9'd1) begin
         errors++;
         $display("FAIL midreset_reload: writes %0d done %0d wl %0d, required 1 1 1",
                  wr_q.size(), done_cnt, words_loaded);
      end else begin
         checks++;
         if (wr_q[0].a !== 32'h0 || wr_q[0].d !== w[0]) begin
            errors++;
            $display("FAIL midreset_reload_data: got %h@%h, required %h@0", wr_q[0].d, wr_q[0].a, w[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_len();
      test_timeout();
      test_gaps();
      test_full();
      test_midreset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within 50000 cycles");
      $fatal(1, "watchdog");
   end

endmodule
